// File: rtl/keyed_sec_pipe.sv
// Key-locked single-error-correcting Hamming decoder with serial key load
// and a two-stage valid/ready correction pipeline.
module keyed_sec_pipe #(
  parameter int DATA_W = 32,
  parameter int CHK_W  = 6,
  parameter logic [DATA_W+3:0] CORRECT_KEY = {4'b0110, 32'hA5C30F96}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_start,
  input  logic              key_bit,
  input  logic              key_valid,
  input  logic              key_clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] din,
  input  logic [CHK_W-1:0]  chk_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dout,
  output logic              err_corr,
  output logic              err_uncorr,
  output logic [1:0]        key_state
);

  localparam int KEY_W = DATA_W + 4;
  localparam int CNT_W = $clog2(KEY_W);

  if ((2 ** CHK_W) - CHK_W - 1 < DATA_W) begin : g_bad_widths
    $error("keyed_sec_pipe: CHK_W too small to cover DATA_W data columns");
  end

  // H-matrix column of data bit idx: the (idx+1)-th integer >= 3 that is not a power of two.
  function automatic logic [CHK_W-1:0] col_of(input int idx);
    logic [CHK_W-1:0] res;
    int seen;
    res  = '0;
    seen = 0;
    for (int v = 3; v < (1 << CHK_W); v++) begin
      if ((v & (v - 1)) != 0) begin
        if (seen == idx) res = v[CHK_W-1:0];
        seen++;
      end
    end
    return res;
  endfunction

  function automatic logic [DATA_W-1:0] mask_of(input int bit_j);
    logic [DATA_W-1:0] m;
    logic [CHK_W-1:0]  c;
    m = '0;
    for (int i = 0; i < DATA_W; i++) begin
      c    = col_of(i);
      m[i] = c[bit_j];
    end
    return m;
  endfunction

  // state | meaning
  // IDLE  | no key held, inputs blocked
  // LOAD  | shifting key bits in, LSB first
  // ARMED | key complete, words accepted
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_ARMED = 2'b10
  } key_st_e;

  key_st_e          st_q;
  logic [KEY_W-1:0] key_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= ST_IDLE;
      key_q <= '0;
      cnt_q <= '0;
    end else if (key_clear) begin
      st_q  <= ST_IDLE;
      key_q <= '0;
      cnt_q <= '0;
    end else if (key_start) begin
      st_q  <= ST_LOAD;
      cnt_q <= '0;
    end else if (st_q == ST_LOAD && key_valid) begin
      key_q[cnt_q] <= key_bit;
      if (cnt_q == CNT_W'(KEY_W - 1)) begin
        st_q  <= ST_ARMED;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign key_state = st_q;

  logic              s1_valid_q;
  logic [DATA_W-1:0] eff_q;
  logic [CHK_W-1:0]  syn_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] dout_q;
  logic              err_corr_q;
  logic              err_uncorr_q;

  logic s1_advance;
  logic accept;

  assign s1_advance = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready   = (st_q == ST_ARMED) && !key_start && (!s1_valid_q || s1_advance);
  assign accept     = in_valid && in_ready;

  logic [DATA_W-1:0] eff_d;
  logic [CHK_W-1:0]  par;
  logic [CHK_W-1:0]  syn_d;
  logic [3:0]        tt;

  assign tt    = key_q[KEY_W-1:DATA_W];
  assign eff_d = din ^ key_q[DATA_W-1:0] ^ CORRECT_KEY[DATA_W-1:0];

  for (genvar j = 0; j < CHK_W; j++) begin : g_par
    localparam logic [DATA_W-1:0] MASK = mask_of(j);
    assign par[j] = ^(eff_d & MASK);
  end

  // Syndrome bit 0 goes through the keyed truth table; the correct table is XOR.
  assign syn_d = {chk_in[CHK_W-1:1] ^ par[CHK_W-1:1], tt[{par[0], chk_in[0]}]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      eff_q      <= '0;
      syn_q      <= '0;
    end else begin
      if (key_clear)       s1_valid_q <= 1'b0;
      else if (accept)     s1_valid_q <= 1'b1;
      else if (s1_advance) s1_valid_q <= 1'b0;
      if (accept) begin
        eff_q <= eff_d;
        syn_q <= syn_d;
      end
    end
  end

  logic [DATA_W-1:0] hit;
  logic              dec_corr;
  logic              dec_uncorr;

  for (genvar i = 0; i < DATA_W; i++) begin : g_hit
    localparam logic [CHK_W-1:0] COL = col_of(i);
    assign hit[i] = (syn_q == COL);
  end

  // Columns are distinct, so hit is at most one-hot and doubles as the flip mask.
  assign dec_corr   = (|hit) || $onehot(syn_q);
  assign dec_uncorr = (syn_q != '0) && !dec_corr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      dout_q       <= '0;
      err_corr_q   <= 1'b0;
      err_uncorr_q <= 1'b0;
    end else begin
      if (key_clear)       out_valid_q <= 1'b0;
      else if (s1_advance) out_valid_q <= 1'b1;
      else if (out_ready)  out_valid_q <= 1'b0;
      if (s1_advance) begin
        dout_q       <= eff_q ^ hit;
        err_corr_q   <= dec_corr;
        err_uncorr_q <= dec_uncorr;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign dout       = dout_q;
  assign err_corr   = err_corr_q;
  assign err_uncorr = err_uncorr_q;

endmodule
